// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack handshake and fills the
// one-entry IF/ID output slot. Redirects discard wrong-path work without abandoning requests.
module fetch_unit #(
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_out_o,
  output logic [31:0] pcplus4_out_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [31:0] buf_inst_q;
  logic [31:0] buf_pc4_q;
  logic [31:0] inst_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32; no alignment check on the PC.
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      pc_q       <= ResetPc;
      tgt_q      <= '0;
      buf_inst_q <= '0;
      buf_pc4_q  <= '0;
      inst_q     <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StFetch;
        end

        StFetch: begin
          if (redirect_i) begin
            inst_q  <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            if (imem_ack_i) begin
              pc_q <= redirect_pc_i;
            end else begin
              // Request must complete at the old address before the target is fetched.
              tgt_q   <= redirect_pc_i;
              state_q <= StDrain;
            end
          end else if (imem_ack_i) begin
            pc_q <= pc_plus4;
            if (stall_i) begin
              buf_inst_q <= imem_rdata_i;
              buf_pc4_q  <= pc_plus4;
              state_q    <= StHold;
            end else begin
              inst_q  <= imem_rdata_i;
              pc4_q   <= pc_plus4;
              valid_q <= 1'b1;
            end
          end else if (!stall_i) begin
            inst_q  <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
          end
        end

        StHold: begin
          if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            inst_q  <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            state_q <= StFetch;
          end else if (!stall_i) begin
            inst_q  <= buf_inst_q;
            pc4_q   <= buf_pc4_q;
            valid_q <= 1'b1;
            state_q <= StFetch;
          end
        end

        StDrain: begin
          if (redirect_i) begin
            tgt_q <= redirect_pc_i;
          end
          if (imem_ack_i) begin
            pc_q    <= redirect_i ? redirect_pc_i : tgt_q;
            state_q <= StFetch;
          end
          inst_q  <= '0;
          pc4_q   <= '0;
          valid_q <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign imem_req_o    = (state_q == StFetch) || (state_q == StDrain);
  assign imem_addr_o   = pc_q;
  assign inst_out_o    = inst_q;
  assign pcplus4_out_o = pc4_q;
  assign inst_valid_o  = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus a randomized run checked against an
// in-order instruction-stream model with a variable-latency memory (data = addr + 0x100).
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] pcplus4_out;
  logic        inst_valid;

  int vectors = 0;
  int errors  = 0;

  // Memory model state: wait cycles for the current access and cycles waited so far.
  int wait_n;
  int wait_cnt;
  int wait_max;
  bit wait_rand;
  bit last_ack;

  logic [97:0] obs;
  assign obs = {imem_req, imem_addr, inst_out, pcplus4_out, inst_valid};

  fetch_unit dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .inst_out_o   (inst_out),
    .pcplus4_out_o(pcplus4_out),
    .inst_valid_o (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    wait_cnt = 0;
    wait_n   = wait_rand ? int'($urandom_range(wait_max, 0)) : wait_max;
  endtask

  // One clock: drive inputs, answer the memory handshake, sample 1ns after the edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    logic req_b;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    req_b       = imem_req;
    imem_ack    = req_b && (wait_cnt >= wait_n);
    imem_rdata  = imem_ack ? imem_addr + 32'h100 : 32'hDEAD_BEEF;
    last_ack    = imem_ack;
    @(posedge clk);
    #1;
    if (last_ack) begin
      wait_cnt = 0;
      wait_n   = wait_rand ? int'($urandom_range(wait_max, 0)) : wait_max;
    end else if (req_b) begin
      wait_cnt++;
    end
    imem_ack = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    wait_rand = 0;
    wait_max  = 0;
    reset     = 1'b1;
    stall     = 1'b0;
    redirect  = 1'b0;
    imem_ack  = 1'b0;
    #3;
    vectors++;
    if (obs !== 98'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, 98'd0);
    end
  endtask

  task automatic test_zero_wait();
    logic [97:0] e [4];
    e = '{{1'b1, 32'h0, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h4, 32'h100, 32'h4, 1'b1},
          {1'b1, 32'h8, 32'h104, 32'h8, 1'b1},
          {1'b1, 32'hC, 32'h108, 32'hC, 1'b1}};
    wait_rand = 0;
    wait_max  = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      vectors++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL zero_wait edge%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [97:0] e [7];
    e = '{{1'b1, 32'h0, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h0, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h0, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h4, 32'h100, 32'h4, 1'b1},
          {1'b1, 32'h4, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h4, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h8, 32'h104, 32'h8, 1'b1}};
    wait_rand = 0;
    wait_max  = 2;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 32'h0);
      vectors++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL wait_states edge%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [97:0] e [7];
    logic [6:0]  st;
    st = 7'b0011100;
    e = '{{1'b1, 32'h0, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h4, 32'h100, 32'h4, 1'b1},
          {1'b0, 32'h8, 32'h100, 32'h4, 1'b1},
          {1'b0, 32'h8, 32'h100, 32'h4, 1'b1},
          {1'b0, 32'h8, 32'h100, 32'h4, 1'b1},
          {1'b1, 32'h8, 32'h104, 32'h8, 1'b1},
          {1'b1, 32'hC, 32'h108, 32'hC, 1'b1}};
    wait_rand = 0;
    wait_max  = 0;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step(st[i], 1'b0, 32'h0);
      vectors++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL stall_hold edge%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_redirect_drain();
    logic [97:0] e [10];
    logic [31:0] rpc [10];
    e = '{{1'b1, 32'h0,   32'h0,   32'h0,   1'b0},
          {1'b1, 32'h4,   32'h100, 32'h4,   1'b1},
          {1'b1, 32'h8,   32'h104, 32'h8,   1'b1},
          {1'b1, 32'hC,   32'h108, 32'hC,   1'b1},
          {1'b1, 32'h10,  32'h10C, 32'h10,  1'b1},
          {1'b1, 32'h10,  32'h0,   32'h0,   1'b0},
          {1'b1, 32'h10,  32'h0,   32'h0,   1'b0},
          {1'b1, 32'h10,  32'h0,   32'h0,   1'b0},
          {1'b1, 32'h800, 32'h0,   32'h0,   1'b0},
          {1'b1, 32'h804, 32'h900, 32'h804, 1'b1}};
    rpc = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h400, 32'h800, 32'h0, 32'h0, 32'h0};
    wait_rand = 0;
    wait_max  = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, rpc[i] != 32'h0, rpc[i]);
      vectors++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL redirect_drain edge%0d: got %h want %h", i, obs, e[i]);
      end
      if (i == 4) begin
        wait_n   = 3;
        wait_cnt = 0;
      end
    end
  endtask

  task automatic test_wrap();
    logic [97:0] e [4];
    logic [31:0] rpc [4];
    e = '{{1'b1, 32'h0,         32'h0,   32'h0, 1'b0},
          {1'b1, 32'hFFFF_FFFC, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h0,         32'hFC,  32'h0, 1'b1},
          {1'b1, 32'h4,         32'h100, 32'h4, 1'b1}};
    rpc = '{32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0};
    wait_rand = 0;
    wait_max  = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, rpc[i] != 32'h0, rpc[i]);
      vectors++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL wrap edge%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [97:0] e [5];
    logic [4:0]  st;
    st = 5'b00100;
    e = '{{1'b1, 32'h0, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h4, 32'h100, 32'h4, 1'b1},
          {1'b0, 32'h8, 32'h100, 32'h4, 1'b1},
          {1'b1, 32'h0, 32'h0,   32'h0, 1'b0},
          {1'b1, 32'h4, 32'h100, 32'h4, 1'b1}};
    wait_rand = 0;
    wait_max  = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(st[i], 1'b0, 32'h0);
      vectors++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL async_reset pre edge%0d: got %h want %h", i, obs, e[i]);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 98'd0) begin
      errors++;
      $display("FAIL async_reset mid_hold: got %h want %h", obs, 98'd0);
    end
    apply_reset();
    for (int i = 3; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      vectors++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL async_reset restart edge%0d: got %h want %h", i - 3, obs, e[i]);
      end
    end
  endtask

  // Random stall/redirect/wait traffic checked against the in-order stream of delivered PCs.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] rpc;
    logic [31:0] addr_b;
    logic [64:0] slot_b;
    logic        s;
    logic        r;
    logic        req_b;
    int          delivered;
    wait_rand = 1;
    wait_max  = 3;
    apply_reset();
    exp_pc    = 32'h0;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      s   = ($urandom_range(99, 0) < 30);
      r   = ($urandom_range(99, 0) < 4);
      rpc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
      slot_b = {inst_out, pcplus4_out, inst_valid};
      req_b  = imem_req;
      addr_b = imem_addr;
      if (!s && !r && slot_b[0]) begin
        vectors++;
        if (slot_b[64:1] !== {exp_pc + 32'h100, exp_pc + 32'h4}) begin
          errors++;
          $display("FAIL random_stream cyc%0d: got inst=%h pc4=%h want inst=%h pc4=%h", i,
                   slot_b[64:33], slot_b[32:1], exp_pc + 32'h100, exp_pc + 32'h4);
        end
        exp_pc = exp_pc + 32'h4;
        delivered++;
      end
      if (r) exp_pc = rpc;
      step(s, r, rpc);
      if (s && !r) begin
        vectors++;
        if ({inst_out, pcplus4_out, inst_valid} !== slot_b) begin
          errors++;
          $display("FAIL random_stall_freeze cyc%0d: got %h want %h", i,
                   {inst_out, pcplus4_out, inst_valid}, slot_b);
        end
      end
      if (r) begin
        vectors++;
        if ({inst_out, pcplus4_out, inst_valid} !== 65'd0) begin
          errors++;
          $display("FAIL random_redirect_bubble cyc%0d: got %h want 0", i,
                   {inst_out, pcplus4_out, inst_valid});
        end
      end
      if (!inst_valid) begin
        vectors++;
        if ({inst_out, pcplus4_out} !== 64'd0) begin
          errors++;
          $display("FAIL random_bubble_zero cyc%0d: got %h want 0", i, {inst_out, pcplus4_out});
        end
      end
      if (req_b && !last_ack) begin
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, addr_b}) begin
          errors++;
          $display("FAIL random_req_hold cyc%0d: got req=%b addr=%h want req=1 addr=%h", i,
                   imem_req, imem_addr, addr_b);
        end
      end
    end
    vectors++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL random_progress: got %0d instructions want at least 200", delivered);
    end
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    wait_n      = 0;
    wait_cnt    = 0;
    wait_max    = 0;
    wait_rand   = 0;
    last_ack    = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_redirect_drain();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline and the producer side of the IF/ID register. It owns the PC and issues word requests to instruction memory over a req/ack handshake, tolerating any number of wait cycles. Each fetched instruction is presented with its PC+4 in a one-entry output slot that IF/ID loads whenever the pipeline is not stalled. Branch/jump redirects discard wrong-path work, including a request already in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- imem_req  out  1  fetch request; held until acked
- imem_addr  out  32  word address of the request; stable while imem_req=1
- imem_ack  in  1  rdata valid; sampled at the edge while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- stall  in  1  IF/ID not loading this cycle (IF/ID en = ~stall)
- redirect  in  1  taken branch/jump; one-cycle pulse
- redirect_pc  in  32  target, valid with redirect
- inst_out  out  32  output-slot instruction; 0 (NOP) when invalid
- pcplus4_out  out  32  output-slot PC+4; 0 when invalid
- inst_valid  out  1  output slot holds a correct-path instruction

## Operation
- Registers: pc (address being fetched), tgt (pending redirect target), buf_inst / buf_pc4 (skid entry), output slot {inst_out, pcplus4_out, inst_valid}, state.
- Output slot consumption: IF/ID consumes the slot at any edge with stall=0.
- Bubble: inst_out=0, pcplus4_out=0, inst_valid=0.
- imem_req=1 in FETCH and DRAIN, else 0. imem_addr=pc in all states.
- Reset (async): state=IDLE, pc=RESET_PC, tgt=0, buffers=0, inst_out=0, pcplus4_out=0, inst_valid=0, imem_req=0.
- IDLE: next edge -> FETCH.
- FETCH, evaluated at each edge in priority order:
  - redirect & ack: drop data; pc<=redirect_pc; slot<=bubble; stay FETCH.
  - redirect & !ack: tgt<=redirect_pc; slot<=bubble; -> DRAIN. The request stays up at the old address.
  - ack & !stall: slot<={imem_rdata, pc+4, 1}; pc<=pc+4; stay FETCH.
  - ack & stall: buf<={imem_rdata, pc+4}; slot unchanged; pc<=pc+4; -> HOLD.
  - !ack & !stall: slot<=bubble; stay FETCH.
  - !ack & stall: no change.
- HOLD (req=0):
  - redirect: drop buf; pc<=redirect_pc; slot<=bubble; -> FETCH.
  - !stall: slot<={buf_inst, buf_pc4, 1}; -> FETCH.
  - stall: no change.
- DRAIN (req=1, addr=old pc):
  - redirect: tgt<=redirect_pc (latest wins).
  - ack: drop data; pc<=redirect ? redirect_pc : tgt; -> FETCH.
  - Slot stays bubble.
- Redirect has priority over stall and always bubbles the slot.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No alignment check is performed; redirect_pc is used as given.
- Every in-flight request is completed before imem_addr changes. No request is ever abandoned mid-handshake.

## Timing
- Zero-wait memory (ack in the same cycle as req):
  - Edge 0 after reset release: IDLE->FETCH.
  - Edge 1: slot valid with the RESET_PC instruction.
  - Thereafter one instruction per cycle while stall=0.
- N wait cycles: slot is bubble for N cycles, then valid 1 edge after ack.
- Redirect with req acked in the same cycle: the target is requested in the next cycle and its instruction is valid 1 edge later (zero-wait).
- Redirect during a wait: DRAIN lasts until the old ack, then the target request is issued.
- Stall release from HOLD: buffered instruction appears at the next edge. The request for the following PC is issued in the cycle after that edge.
- Reset mid-request: all state clears immediately; imem_req drops asynchronously. Memory must tolerate an abandoned request on reset only.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning addr+0x100: slot sequence {0x100,4,1},{0x104,8,1},{0x108,12,1} on edges 1,2,3.
- Memory inserts 2 wait cycles per access: imem_addr stable for 3 cycles; slot bubble (all 0) for 2 edges, then valid; pc advances by 4 per ack only.
- stall=1 for 3 cycles while an ack arrives: slot frozen, state HOLD, imem_req=0; on release the buffered instruction appears next edge with correct pcplus4 and no instruction is lost or duplicated.
- redirect to 0x400 while a request to 0x10 waits 3 cycles, plus a second redirect to 0x800 during DRAIN: imem_addr stays 0x10 until ack, data is discarded, next request is 0x800, and slot stays bubble throughout.
- pc=0xFFFF_FFFC, zero-wait: slot pcplus4_out=0, next imem_addr=0.
- Async reset asserted mid-HOLD: outputs zero and imem_req=0 without a clock edge; after release, fetch restarts at RESET_PC.
